// File: rtl/shift_reg_seq_if.sv
// Control/data bundle for shift_reg_seq: master drives commands, slave returns register state.
// Count is sized to hold 0..WIDTH.
interface shift_reg_seq_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             Clear;
  logic             Load;
  logic [WIDTH-1:0] Data_In;
  logic             Shift_En;
  logic             Dir;
  logic             Arith;
  logic             Shift_In;
  logic             Start;
  logic [CW-1:0]    Count;
  logic [WIDTH-1:0] Data_Out;
  logic             Shift_Out;
  logic             Busy;
  logic             Done;

  modport master (
    output Clear, Load, Data_In, Shift_En, Dir, Arith, Shift_In, Start, Count,
    input  Data_Out, Shift_Out, Busy, Done
  );

  modport slave (
    input  Clear, Load, Data_In, Shift_En, Dir, Arith, Shift_In, Start, Count,
    output Data_Out, Shift_Out, Busy, Done
  );
endinterface

// File: rtl/shift_reg_seq.sv
// Shift register with load/clear/single shift and a self-timed N-shift burst (Busy/Done).
// All results appear one cycle after the edge; Start/Load/Shift_En are dropped while Busy.
module shift_reg_seq #(
  parameter int WIDTH = 16
) (
  input  logic           Clk,
  input  logic           Reset_n,
  shift_reg_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic             shift_out_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    remaining_q;
  logic             dir_q;
  logic             arith_q;

  logic             sh_dir;
  logic             sh_arith;
  logic             fill;
  logic [WIDTH-1:0] data_sh_d;
  logic             shift_out_sh_d;

  // A burst uses the direction/mode captured at Start; Shift_In stays live.
  always_comb begin
    sh_dir         = (state_q == RUN) ? dir_q   : bus.Dir;
    sh_arith       = (state_q == RUN) ? arith_q : bus.Arith;
    fill           = sh_arith ? data_q[WIDTH-1] : bus.Shift_In;
    data_sh_d      = {fill, data_q[WIDTH-1:1]};
    shift_out_sh_d = data_q[0];
    if (sh_dir) begin
      data_sh_d      = {data_q[WIDTH-2:0], bus.Shift_In};
      shift_out_sh_d = data_q[WIDTH-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      shift_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      arith_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.Clear) begin
        state_q     <= IDLE;
        data_q      <= '0;
        shift_out_q <= 1'b0;
        busy_q      <= 1'b0;
        remaining_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.Start) begin
              dir_q       <= bus.Dir;
              arith_q     <= bus.Arith;
              remaining_q <= bus.Count;
              if (bus.Count != '0) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
              end else begin
                done_q <= 1'b1;
              end
            end else if (bus.Load) begin
              data_q <= bus.Data_In;
            end else if (bus.Shift_En) begin
              data_q      <= data_sh_d;
              shift_out_q <= shift_out_sh_d;
            end
          end
          RUN: begin
            data_q      <= data_sh_d;
            shift_out_q <= shift_out_sh_d;
            remaining_q <= remaining_q - CW'(1);
            if (remaining_q == CW'(1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Data_Out  = data_q;
  assign bus.Shift_Out = shift_out_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
endmodule

// File: tb/tb_shift_reg_seq.sv
// Directed bench for shift_reg_seq at WIDTH=8: per-edge vector table plus burst-length sequences.
module tb_shift_reg_seq;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shift_reg_seq_if #(.WIDTH(W)) bus ();

  shift_reg_seq #(.WIDTH(W)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst_n;
    logic          clr;
    logic          ld;
    logic [W-1:0]  din;
    logic          sen;
    logic          dir;
    logic          ar;
    logic          sin;
    logic          st;
    logic [CW-1:0] cnt;
    logic [W-1:0]  e_dout;
    logic          e_so;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic l, input logic [W-1:0] d,
                       input logic se, input logic dr, input logic a, input logic si,
                       input logic s, input logic [CW-1:0] n);
    rst_n        = r;
    bus.Clear    = c;
    bus.Load     = l;
    bus.Data_In  = d;
    bus.Shift_En = se;
    bus.Dir      = dr;
    bus.Arith    = a;
    bus.Shift_In = si;
    bus.Start    = s;
    bus.Count    = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1, 0, 0, '0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;
    drive(0, 0, 0, '0, 0, 0, 0, 0, 0, '0);

    //          rst clr ld din    sen dir ar sin st cnt   dout  so bsy dn
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 8'hA5, 0, 0, 0, 0, 0, 4'd0, 8'hA5, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 8'h96, 0, 0, 0, 0, 0, 4'd0, 8'h96, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 4'd3, 8'h96, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 4'd0, 8'hCB, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 4'd0, 8'hE5, 1, 1, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 4'd0, 8'hF2, 1, 0, 1});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'hF2, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 8'h81, 0, 0, 0, 0, 0, 4'd0, 8'h81, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 1, 1, 0, 1, 0, 4'd0, 8'h03, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 4'd0, 8'h01, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 4'd0, 8'h01, 1, 0, 1});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h01, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 8'h3C, 0, 0, 0, 0, 0, 4'd0, 8'h3C, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 1, 0, 0, 1, 4'd5, 8'h3C, 1, 1, 0});
    vecs.push_back('{1, 0, 1, 8'hFF, 1, 0, 0, 1, 0, 4'd0, 8'h79, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 4'd1, 8'hF2, 0, 1, 0});
    vecs.push_back('{1, 1, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 8'h5A, 0, 0, 0, 0, 0, 4'd0, 8'h5A, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 1, 1, 4'd2, 8'h5A, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 4'd0, 8'hAD, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 8'h0F, 0, 0, 0, 0, 0, 4'd0, 8'h0F, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 4'd1, 8'h0F, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h07, 1, 0, 1});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h07, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 8'h80, 0, 0, 0, 0, 0, 4'd0, 8'h80, 1, 0, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 1, 0, 1, 0, 0, 4'd0, 8'hC0, 0, 0, 0});
    vecs.push_back('{1, 0, 1, 8'h55, 0, 0, 0, 0, 1, 4'd1, 8'hC0, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h60, 0, 0, 1});
    vecs.push_back('{1, 1, 1, 8'h77, 1, 0, 0, 0, 1, 4'd3, 8'h00, 0, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].clr, vecs[i].ld, vecs[i].din, vecs[i].sen,
            vecs[i].dir, vecs[i].ar, vecs[i].sin, vecs[i].st, vecs[i].cnt);
      step();
      chk($sformatf("v%0d Data_Out", i), 32'(bus.Data_Out), 32'(vecs[i].e_dout));
      chk($sformatf("v%0d Shift_Out", i), 32'(bus.Shift_Out), 32'(vecs[i].e_so));
      chk($sformatf("v%0d Busy", i), 32'(bus.Busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d Done", i), 32'(bus.Done), 32'(vecs[i].e_done));
    end

    // Count larger than WIDTH: ten left shifts of 0x01 with Shift_In=1.
    drive(1, 0, 1, 8'h01, 0, 0, 0, 0, 0, '0);
    step();
    drive(1, 0, 0, '0, 0, 1, 0, 1, 1, 4'd10);
    step();
    chk("long start Busy", 32'(bus.Busy), 32'd1);
    drive(1, 0, 0, '0, 0, 0, 0, 1, 0, '0);
    cyc = 0;
    while (bus.Done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk("long burst edges", 32'(cyc), 32'd10);
    chk("long Data_Out", 32'(bus.Data_Out), 32'hFF);
    chk("long Shift_Out", 32'(bus.Shift_Out), 32'd1);
    chk("long Busy end", 32'(bus.Busy), 32'd0);

    // Start in the Done cycle is accepted: two logical right shifts of 0xFF.
    drive(1, 0, 0, '0, 0, 0, 0, 0, 1, 4'd2);
    step();
    chk("b2b start Busy", 32'(bus.Busy), 32'd1);
    chk("b2b start Done", 32'(bus.Done), 32'd0);
    idle();
    cyc = 0;
    while (bus.Done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    chk("b2b burst edges", 32'(cyc), 32'd2);
    chk("b2b Data_Out", 32'(bus.Data_Out), 32'h3F);
    chk("b2b Shift_Out", 32'(bus.Shift_Out), 32'd1);
    step();
    chk("b2b Done drop", 32'(bus.Done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
